recip_nr_sequencer: RTL

Multi-cycle Newton-Raphson reciprocal engine for the Quaternion Normalizer's division path. It computes 1/x for an unsigned Q2.30 operand using a 12-bit seed lookup and a programmable number of refinement iterations. All iterations share one 32x32 multiplier, and a small FSM sequences the work. Valid/ready handshakes on both sides let the normalizer stall it or be stalled by it.

---
 rtl/recip_pkg.sv | 27 ++
 rtl/recip_seed_lut.sv | 18 +
 rtl/recip_nr_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/recip_pkg.sv
// Shared types and Q2.30 constants for the Newton-Raphson reciprocal engine.
// Also holds the seed function that the ROM is built from at elaboration.
package recip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_MUL_A,
    ST_MUL_B,
    ST_DONE
  } state_e;

  localparam logic [31:0] TWO_Q230    = 32'h8000_0000;
  localparam logic [31:0] SAT_Q230    = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_IN_Q230 = 32'h1000_0000;

  localparam int unsigned ITERS_MIN = 1;
  localparam int unsigned ITERS_MAX = 4;

  // Reciprocal at the midpoint of the address interval, so the seed stays below 2/x.
  function automatic logic [31:0] seed_q230(input logic [11:0] a);
    logic [63:0] q;
    q = (64'd1 << 41) / {51'd0, a, 1'b1};
    return (q > {32'd0, SAT_Q230}) ? SAT_Q230 : 32'(q);
  endfunction

endpackage

// File: rtl/recip_seed_lut.sv
// Combinational 4096-entry seed ROM indexed by the top 12 bits of the operand.
// Contents are constant-folded at elaboration from seed_q230().
module recip_seed_lut
  import recip_pkg::*;
(
  input  logic [11:0] addr_i,
  output logic [31:0] seed_o
);

  logic [31:0] rom [4096];

  for (genvar i = 0; i < 4096; i++) begin : g_rom
    assign rom[i] = seed_q230(12'(i));
  end

  assign seed_o = rom[addr_i];

endmodule

// File: rtl/recip_nr_sequencer.sv
// Multi-cycle Newton-Raphson reciprocal of an unsigned Q2.30 operand.
// One shared 32x32 multiplier alternates between x*y and y*(2-x*y).
module recip_nr_sequencer
  import recip_pkg::*;
#(
  parameter int unsigned ITERS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_dz,
  output logic        out_sat,
  output logic        busy
);

  // Out-of-range ITERS is clamped to the legal 1..4 window.
  localparam logic [2:0] ITERS_L = (ITERS < ITERS_MIN) ? 3'(ITERS_MIN) :
                                   (ITERS > ITERS_MAX) ? 3'(ITERS_MAX) : 3'(ITERS);

  state_e      state_q;
  logic [31:0] x_q, y_q, t_q;
  logic [2:0]  it_q;
  logic        out_valid_q, out_dz_q, out_sat_q;
  logic [31:0] out_y_q;

  logic [31:0] seed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] prod;
  logic [31:0] p_w;
  logic [33:0] q_w;
  logic [31:0] t_d, y_d;

  recip_seed_lut u_lut (
    .addr_i (x_q[31:20]),
    .seed_o (seed)
  );

  always_comb begin
    mul_a = x_q;
    mul_b = y_q;
    if (state_q == ST_MUL_B) begin
      mul_a = y_q;
      mul_b = t_q;
    end
  end

  assign prod = {32'd0, mul_a} * {32'd0, mul_b};
  assign p_w  = 32'(prod >> 30);
  assign q_w  = 34'(prod >> 30);
  // Clamp 2 - x*y at zero rather than letting it wrap.
  assign t_d  = (p_w >= TWO_Q230) ? 32'd0 : TWO_Q230 - p_w;
  assign y_d  = (q_w > {2'b00, SAT_Q230}) ? SAT_Q230 : q_w[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      it_q        <= 3'd0;
      out_valid_q <= 1'b0;
      out_y_q     <= 32'd0;
      out_dz_q    <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q <= in_x;
            if (in_x == 32'd0) begin
              out_y_q     <= SAT_Q230;
              out_dz_q    <= 1'b1;
              out_sat_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (in_x <= MIN_IN_Q230) begin
              out_y_q     <= SAT_Q230;
              out_dz_q    <= 1'b0;
              out_sat_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_SEED;
            end
          end
        end
        ST_SEED: begin
          y_q     <= seed;
          it_q    <= 3'd0;
          state_q <= ST_MUL_A;
        end
        ST_MUL_A: begin
          t_q     <= t_d;
          state_q <= ST_MUL_B;
        end
        ST_MUL_B: begin
          y_q  <= y_d;
          it_q <= it_q + 3'd1;
          if (it_q + 3'd1 < ITERS_L) begin
            state_q <= ST_MUL_A;
          end else begin
            out_y_q     <= y_d;
            out_dz_q    <= 1'b0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_dz    = out_dz_q;
  assign out_sat   = out_sat_q;

endmodule
